// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the serial BCD adder family.
package bcd_pkg;

    localparam int DIGIT_W        = 4;
    localparam int DEFAULT_DIGITS = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_4adder.sv
// Single-digit BCD adder: sum = a + b + cin with decimal carry out.
module bcd_4adder
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    logic [DIGIT_W:0] raw_s;

    // Binary sum, then +6 correction whenever the result passes 9
    always_comb begin
        raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw_s > 5'd9) begin
            sum  = raw_s[DIGIT_W-1:0] + 4'd6;
            cout = 1'b1;
        end else begin
            sum  = raw_s[DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD add (and subtract when BCD_SUB_EN is defined), one digit per clock, LSD first.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
`ifdef BCD_SUB_EN
    input  logic                      sub,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] s,
    output logic                      cout,
    output logic                      err
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t               state_r;
    logic [W-1:0]         a_r, b_r, s_r;
    logic [IW-1:0]        idx_r;
    logic                 carry_r, cout_r, err_r, busy_r, done_r;
    logic [DIGIT_W-1:0]   a_dig_s, b_dig_s, b_eff_s, sum_dig_s;
    logic                 dig_cout_s, last_s, init_carry_s;
`ifdef BCD_SUB_EN
    logic                 sub_r;
`endif

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] > 4'd9) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    // Current digit pair and operation-dependent addend / initial carry
    always_comb begin
        a_dig_s = a_r[idx_r*DIGIT_W +: DIGIT_W];
        b_dig_s = b_r[idx_r*DIGIT_W +: DIGIT_W];
        last_s  = (idx_r == IW'(DIGITS-1));
`ifdef BCD_SUB_EN
        if (sub_r) begin
            b_eff_s = 4'd9 - b_dig_s;
        end else begin
            b_eff_s = b_dig_s;
        end
        init_carry_s = sub;
`else
        b_eff_s      = b_dig_s;
        init_carry_s = 1'b0;
`endif
    end

    bcd_4adder u_digit_add (
        .a    (a_dig_s),
        .b    (b_eff_s),
        .cin  (carry_r),
        .sum  (sum_dig_s),
        .cout (dig_cout_s)
    );

    // Control FSM with registered status and result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            idx_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef BCD_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
`ifdef BCD_SUB_EN
                        sub_r   <= sub;
`endif
                        s_r     <= '0;
                        idx_r   <= '0;
                        carry_r <= init_carry_s;
                        cout_r  <= 1'b0;
                        err_r   <= has_bad_digit(a) | has_bad_digit(b);
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    s_r[idx_r*DIGIT_W +: DIGIT_W] <= sum_dig_s;
                    carry_r <= dig_cout_s;
                    if (last_s) begin
                        cout_r  <= dig_cout_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + IW'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
    assign err  = err_r;

endmodule
